axi_lite_reg_file_multi_master: RTL and testbench



---
 rtl/axi_lite_reg_pkg.sv | 45 ++++
 rtl/axi_lite_reg_file_multi_master_if.sv | 33 +++
 rtl/axi_lite_reg_file_multi_master_cell.sv | 89 ++++++++
 rtl/axi_lite_reg_file_multi_master.sv | 165 ++++++++++++++++
 tb/tb_axi_lite_reg_file_multi_master.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_reg_pkg.sv
// Shared types, AXI response codes and address helpers for the multi-master
// AXI4-Lite register file.
package axi_lite_reg_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_RW    = 2'd0,
        MODE_RO    = 2'd1,
        MODE_W1C   = 2'd2,
        MODE_PULSE = 2'd3
    } reg_mode_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Word index; bits above the index field are ignored here and are
    // checked separately by addr_in_range.
    function automatic int unsigned addr_to_index(input logic [AXI_ADDR_W-1:0] addr,
                                                  input int unsigned num_regs);
        logic [AXI_ADDR_W-1:0] word;
        word = addr >> 2;
        return word & (num_regs - 1);
    endfunction

    function automatic logic addr_in_range(input logic [AXI_ADDR_W-1:0] addr,
                                           input int unsigned num_regs);
        logic [AXI_ADDR_W-1:0] word;
        word = addr >> 2;
        return word < num_regs;
    endfunction

endpackage

// File: rtl/axi_lite_reg_file_multi_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface ifc_axi4_lite;
    import axi_lite_reg_pkg::*;

    logic [AXI_ADDR_W-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [AXI_DATA_W-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_reg_file_multi_master_cell.sv
// One register: mode-dependent update, hardware/AXI priority resolution and
// collision flag.
module reg_file_mm_cell
    import axi_lite_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter reg_mode_t        MODE        = MODE_RW,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      NUM_MASTERS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         axi_we,
    input  logic [WIDTH-1:0]             axi_wdata,
    input  logic [WIDTH/8-1:0]           axi_wstrb,
    input  logic [NUM_MASTERS-1:0]       hw_req,
    input  logic [NUM_MASTERS*WIDTH-1:0] hw_data,
    output logic [WIDTH-1:0]             value,
    output logic                         collision
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_nxt;
    logic             coll_q;
    logic             coll_nxt;
    logic [WIDTH-1:0] hw_sel;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] axi_val;
    logic [WIDTH-1:0] clr;
    logic             found;
    logic             hw_any;
    logic             hw_multi;
    logic             axi_eff;

    always_comb begin
        hw_sel = '0;
        found  = 1'b0;
        mask   = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (hw_req[m] && !found) begin
                hw_sel = hw_data[m*WIDTH +: WIDTH];
                found  = 1'b1;
            end
        end
        for (int b = 0; b < WIDTH/8; b++) begin
            mask[b*8 +: 8] = {8{axi_wstrb[b]}};
        end
        hw_any   = |hw_req;
        hw_multi = $countones(hw_req) > 1;
        axi_eff  = axi_we && (MODE != MODE_RO);
        axi_val  = (val_q & ~mask) | (axi_wdata & mask);
        clr      = axi_eff ? (axi_wdata & mask) : '0;

        val_nxt  = val_q;
        coll_nxt = hw_multi;
        case (MODE)
            MODE_RW, MODE_RO: begin
                if (hw_any)       val_nxt = hw_sel;
                else if (axi_eff) val_nxt = axi_val;
                coll_nxt = hw_multi | (hw_any & axi_eff);
            end
            // Clear and set merge per bit, so AXI and hardware never collide here.
            MODE_W1C: begin
                val_nxt = (val_q & ~clr) | (hw_any ? hw_sel : '0);
            end
            MODE_PULSE: begin
                val_nxt = RESET_VALUE;
                if (hw_any)       val_nxt = hw_sel;
                else if (axi_eff) val_nxt = (RESET_VALUE & ~mask) | (axi_wdata & mask);
                coll_nxt = hw_multi | (hw_any & axi_eff);
            end
            default: val_nxt = val_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= RESET_VALUE;
            coll_q <= 1'b0;
        end else begin
            val_q  <= val_nxt;
            coll_q <= coll_nxt;
        end
    end

    assign value     = val_q;
    assign collision = coll_q;

endmodule

// File: rtl/axi_lite_reg_file_multi_master.sv
// AXI4-Lite register file with parallel hardware write ports and per-register
// access modes.
//
//   state    | meaning
//   W_IDLE   | waiting for AW and W together; both accepted in one cycle
//   W_COMMIT | register updated, trigger pulsing, bvalid high
//   W_RESP   | bvalid held until bready
//   R_IDLE   | arready high, rdata captured on handshake
//   R_DATA   | rvalid held with stable data until rready
module axi_lite_reg_file_multi_master
    import axi_lite_reg_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH = 32,
    parameter int unsigned NUM_REGISTERS  = 16,
    parameter int unsigned NUM_HW_MASTERS = 2,
    parameter logic [2*NUM_REGISTERS-1:0]              REG_MODES    = '0,
    parameter logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    ifc_axi4_lite.slave                                       if_axi_ctrl,
    input  logic [NUM_HW_MASTERS*NUM_REGISTERS-1:0]           i_hw_write_req,
    input  logic [NUM_HW_MASTERS*NUM_REGISTERS*REGISTER_WIDTH-1:0] i_hw_write_data,
    output logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]           o_reg_data,
    output logic [NUM_REGISTERS-1:0]                          o_axi_ctrl_trigger,
    output logic [NUM_REGISTERS-1:0]                          o_write_collision
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGISTERS);
    localparam int unsigned STRB_W = REGISTER_WIDTH / 8;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic                      awready, wready, bvalid, arready, rvalid;
    logic                      w_hs, ar_hs, wr_commit, aw_ok, ar_ok;
    logic [IDX_W-1:0]          aw_idx, ar_idx;
    reg_mode_t                 aw_mode;
    logic [NUM_REGISTERS-1:0]  axi_we;
    logic [NUM_REGISTERS-1:0]  trigger_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [AXI_DATA_W-1:0]     rdata_q;
    logic [REGISTER_WIDTH-1:0] reg_val [NUM_REGISTERS];

    always_comb begin
        aw_idx    = IDX_W'(addr_to_index(if_axi_ctrl.awaddr, NUM_REGISTERS));
        ar_idx    = IDX_W'(addr_to_index(if_axi_ctrl.araddr, NUM_REGISTERS));
        aw_ok     = addr_in_range(if_axi_ctrl.awaddr, NUM_REGISTERS);
        ar_ok     = addr_in_range(if_axi_ctrl.araddr, NUM_REGISTERS);
        aw_mode   = reg_mode_t'(REG_MODES[{aw_idx, 1'b0} +: 2]);
        w_hs      = awready && wready;
        ar_hs     = arready && if_axi_ctrl.arvalid;
        wr_commit = w_hs && aw_ok && (aw_mode != MODE_RO);
        axi_we    = '0;
        if (wr_commit) axi_we[aw_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (if_axi_ctrl.awvalid && if_axi_ctrl.wvalid) begin
                    awready     = 1'b1;
                    wready      = 1'b1;
                    w_state_nxt = W_COMMIT;
                end
            end
            W_COMMIT: begin
                bvalid      = 1'b1;
                w_state_nxt = if_axi_ctrl.bready ? W_IDLE : W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (if_axi_ctrl.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // arready is masked during reset so the port is quiet while held in reset.
    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = !rst;
                if (if_axi_ctrl.arvalid && !rst) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (if_axi_ctrl.rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            trigger_q <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state   <= w_state_nxt;
            r_state   <= r_state_nxt;
            trigger_q <= axi_we;
            if (w_hs) bresp_q <= wr_commit ? RESP_OKAY : RESP_SLVERR;
            if (ar_hs) begin
                rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                rdata_q <= ar_ok ? AXI_DATA_W'(reg_val[ar_idx]) : '0;
            end
        end
    end

    assign if_axi_ctrl.awready = awready;
    assign if_axi_ctrl.wready  = wready;
    assign if_axi_ctrl.bvalid  = bvalid;
    assign if_axi_ctrl.bresp   = bresp_q;
    assign if_axi_ctrl.arready = arready;
    assign if_axi_ctrl.rvalid  = rvalid;
    assign if_axi_ctrl.rresp   = rresp_q;
    assign if_axi_ctrl.rdata   = rdata_q;
    assign o_axi_ctrl_trigger  = trigger_q;

    for (genvar r = 0; r < NUM_REGISTERS; r++) begin : g_reg
        logic [NUM_HW_MASTERS-1:0]                hw_req;
        logic [NUM_HW_MASTERS*REGISTER_WIDTH-1:0] hw_data;

        always_comb begin
            hw_req  = '0;
            hw_data = '0;
            for (int m = 0; m < NUM_HW_MASTERS; m++) begin
                hw_req[m] = i_hw_write_req[m*NUM_REGISTERS + r];
                hw_data[m*REGISTER_WIDTH +: REGISTER_WIDTH] =
                    i_hw_write_data[(m*NUM_REGISTERS + r)*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end

        reg_file_mm_cell #(
            .WIDTH       (REGISTER_WIDTH),
            .MODE        (reg_mode_t'(REG_MODES[2*r +: 2])),
            .RESET_VALUE (RESET_VALUES[r*REGISTER_WIDTH +: REGISTER_WIDTH]),
            .NUM_MASTERS (NUM_HW_MASTERS)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .axi_we    (axi_we[r]),
            .axi_wdata (if_axi_ctrl.wdata[REGISTER_WIDTH-1:0]),
            .axi_wstrb (if_axi_ctrl.wstrb[STRB_W-1:0]),
            .hw_req    (hw_req),
            .hw_data   (hw_data),
            .value     (reg_val[r]),
            .collision (o_write_collision[r])
        );

        assign o_reg_data[r*REGISTER_WIDTH +: REGISTER_WIDTH] = reg_val[r];
    end

endmodule

// File: tb/tb_axi_lite_reg_file_multi_master.sv
// Directed bench for axi_lite_reg_file_multi_master: reset contents, strobes,
// priority, W1C merge, RO/out-of-range errors, PULSE and mid-transaction reset.
module tb_axi_lite_reg_file_multi_master;

    // reg 2 RO, reg 7 W1C, reg 9 PULSE, all others RW
    localparam logic [31:0]  MODES = (32'd1 << 4) | (32'd2 << 14) | (32'd3 << 18);
    localparam logic [511:0] RV    = (512'h12345678 << 32) | (512'h000000C3 << 64) |
                                     (512'hCAFE0000 << 320);

    logic [31:0] rst_tbl [16] = '{32'h0, 32'h12345678, 32'hC3, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE0000, 32'h0,
                                  32'h0, 32'h0, 32'h0, 32'h0};

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    hw_req;
    logic [1023:0]  hw_data;
    logic [511:0]   reg_data;
    logic [15:0]    trig;
    logic [15:0]    coll;
    int             n_vec  = 0;
    int             n_miss = 0;
    logic [31:0]    rd_data;
    logic [1:0]     rd_resp;

    ifc_axi4_lite axi ();

    axi_lite_reg_file_multi_master #(
        .REGISTER_WIDTH (32),
        .NUM_REGISTERS  (16),
        .NUM_HW_MASTERS (2),
        .REG_MODES      (MODES),
        .RESET_VALUES   (RV)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .if_axi_ctrl        (axi.slave),
        .i_hw_write_req     (hw_req),
        .i_hw_write_data    (hw_data),
        .o_reg_data         (reg_data),
        .o_axi_ctrl_trigger (trig),
        .o_write_collision  (coll)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_at(input int r);
        return reg_data[r*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the handshake edge, i.e. inside cycle T+1.
    task automatic wr_start(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        int cyc = 0;
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        @(negedge clk);
        while (!(axi.awready && axi.wready) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("aw_w_handshake", 32'(axi.awready && axi.wready), 32'd1);
        @(posedge clk);
        #1;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        hw_req      = '0;
        hw_data     = '0;
    endtask

    task automatic wr_finish(input int hold, input logic [1:0] exp_resp);
        int cyc = 0;
        axi.bready = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(axi.bvalid), 32'd1);
            @(posedge clk);
            #1;
        end
        axi.bready = 1'b1;
        @(negedge clk);
        while (!axi.bvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bvalid", 32'(axi.bvalid), 32'd1);
        chk("bresp", 32'(axi.bresp), 32'(exp_resp));
        @(posedge clk);
        #1;
        axi.bready = 1'b0;
        chk("bvalid_drop", 32'(axi.bvalid), 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data,
                      output logic [1:0] resp);
        int cyc = 0;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        @(negedge clk);
        while (!axi.arready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!axi.rvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rvalid", 32'(axi.rvalid), 32'd1);
        data = axi.rdata;
        resp = axi.rresp;
        @(posedge clk);
        #1;
        axi.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        hw_req      = '0;
        hw_data     = '0;
        axi.awaddr  = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
        chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_coll", 32'(coll), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 16; r++) begin
            rd(32'(r * 4), rd_data, rd_resp);
            chk($sformatf("rst_rd%0d", r), rd_data, rst_tbl[r]);
            chk("rst_rresp", 32'(rd_resp), 32'd0);
        end
        chk("rst_trig_idle", 32'(trig), 32'd0);
        chk("rst_coll_idle", 32'(coll), 32'd0);

        // byte strobes on RW reg 3, bready held low
        wr_start(32'h0C, 32'hDEADBEEF, 4'b0011);
        chk("t2_reg3", reg_at(3), 32'h0000BEEF);
        chk("t2_trig", 32'(trig), 32'h0008);
        chk("t2_bvalid", 32'(axi.bvalid), 32'd1);
        @(posedge clk);
        #1;
        chk("t2_trig_off", 32'(trig), 32'd0);
        wr_finish(2, 2'b00);
        rd(32'h0C, rd_data, rd_resp);
        chk("t2_rd3", rd_data, 32'h0000BEEF);

        // zero strobe: no update, trigger still pulses, OKAY
        wr_start(32'h0C, 32'hFFFFFFFF, 4'b0000);
        chk("zs_reg3", reg_at(3), 32'h0000BEEF);
        chk("zs_trig", 32'(trig), 32'h0008);
        wr_finish(0, 2'b00);

        // two masters plus AXI on reg 5: master 0 wins
        hw_req[16+5]          = 1'b1;
        hw_data[21*32 +: 32]  = 32'h11;
        hw_req[5]             = 1'b1;
        hw_data[5*32 +: 32]   = 32'h22;
        wr_start(32'h14, 32'h33, 4'b1111);
        chk("t3_reg5", reg_at(5), 32'h22);
        chk("t3_coll", 32'(coll), 32'h0020);
        chk("t3_trig", 32'(trig), 32'h0020);
        @(posedge clk);
        #1;
        chk("t3_coll_off", 32'(coll), 32'd0);
        chk("t3_reg5_hold", reg_at(5), 32'h22);
        wr_finish(0, 2'b00);

        // W1C reg 7: hardware sets, AXI clears, merged
        hw_req[7]           = 1'b1;
        hw_data[7*32 +: 32] = 32'hF0;
        @(posedge clk);
        #1;
        hw_req  = '0;
        hw_data = '0;
        chk("t4_set", reg_at(7), 32'hF0);
        hw_req[7]           = 1'b1;
        hw_data[7*32 +: 32] = 32'h01;
        wr_start(32'h1C, 32'h30, 4'b1111);
        chk("t4_reg7", reg_at(7), 32'hC1);
        chk("t4_coll", 32'(coll), 32'd0);
        wr_finish(0, 2'b00);

        // RO write and out-of-range accesses
        wr_start(32'h08, 32'h1, 4'b1111);
        chk("t5_reg2", reg_at(2), 32'hC3);
        chk("t5_ro_trig", 32'(trig), 32'd0);
        wr_finish(0, 2'b10);
        wr_start(32'h40, 32'hFFFFFFFF, 4'b1111);
        chk("t5_oor_trig", 32'(trig), 32'd0);
        chk("t5_oor_reg0", reg_at(0), 32'h0);
        wr_finish(0, 2'b10);
        rd(32'h40, rd_data, rd_resp);
        chk("t5_oor_rdata", rd_data, 32'h0);
        chk("t5_oor_rresp", 32'(rd_resp), 32'h2);

        // PULSE reg 9: value for one cycle only
        wr_start(32'h24, 32'h5A, 4'b1111);
        chk("pl_reg9", reg_at(9), 32'h5A);
        @(posedge clk);
        #1;
        chk("pl_reg9_back", reg_at(9), 32'h0);
        wr_finish(0, 2'b00);

        // reset while bvalid pending and PULSE holding 1
        wr_start(32'h24, 32'h1, 4'b1111);
        chk("t6_reg9", reg_at(9), 32'h1);
        chk("t6_bvalid", 32'(axi.bvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_bvalid_rst", 32'(axi.bvalid), 32'd0);
        chk("t6_reg9_rst", reg_at(9), 32'h0);
        chk("t6_reg3_rst", reg_at(3), 32'h0);
        chk("t6_reg7_rst", reg_at(7), 32'h0);
        chk("t6_reg1_rst", reg_at(1), 32'h12345678);
        rst = 1'b0;
        @(posedge clk);
        #1;
        wr_start(32'h10, 32'hA5A5A5A5, 4'b1111);
        chk("t6_reg4", reg_at(4), 32'hA5A5A5A5);
        chk("t6_trig", 32'(trig), 32'h0010);
        wr_finish(0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
